// File: rtl/hero_pkg.sv
// -----------------------------------------------------------------------------
// hero_pkg
// Shared definitions for the hero playfield collision tracker:
//   - state_t        : frame-report FSM states (IDLE, SCAN, REPORT)
//   - DEF_NUM_WALLS  : default wall count
//   - DEF_VALID_MASK : default set of walls allowed to report collisions
//   - is_onehot      : true when exactly one bit of a select vector is set
//   - onehot_to_idx  : bit position of the set bit of a one-hot vector
// Both helpers take a vector of MAX_WALLS bits. Callers zero-extend narrower
// selects, so the helpers serve any NUM_WALLS up to MAX_WALLS.
// -----------------------------------------------------------------------------
package hero_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int          DEF_NUM_WALLS  = 16;
    localparam logic [15:0] DEF_VALID_MASK = 16'h0FFF;

    localparam int                   MAX_WALLS = 64;
    localparam logic [MAX_WALLS-1:0] ONE_W     = 64'd1;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [MAX_WALLS-1:0] v);
        return (v != '0) && ((v & (v - ONE_W)) == '0);
    endfunction

    // Returns 0 for an all-zero vector. Callers qualify the result with is_onehot.
    function automatic int onehot_to_idx(input logic [MAX_WALLS-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < MAX_WALLS; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/collision_tracker_if.sv
// -----------------------------------------------------------------------------
// collision_tracker_if
// Bundles the tracker's functional signals.
//   master : the environment. It drives frame_start, active, coll_wall and
//            report_ready, and it observes the results.
//   slave  : the tracker. It drives coll, coll_idx, onehot_err, report_valid,
//            report_mask, report_first, report_any and overrun.
// -----------------------------------------------------------------------------
interface collision_tracker_if
    import hero_pkg::*;
#(
    parameter int NUM_WALLS = DEF_NUM_WALLS,
    parameter int IDXW      = $clog2(NUM_WALLS)
);
    logic                 frame_start;
    logic [NUM_WALLS-1:0] active;
    logic [NUM_WALLS-1:0] coll_wall;
    logic                 report_ready;
    logic                 coll;
    logic [IDXW-1:0]      coll_idx;
    logic                 onehot_err;
    logic                 report_valid;
    logic [NUM_WALLS-1:0] report_mask;
    logic [IDXW-1:0]      report_first;
    logic                 report_any;
    logic                 overrun;

    modport master (
        output frame_start, active, coll_wall, report_ready,
        input  coll, coll_idx, onehot_err, report_valid, report_mask,
               report_first, report_any, overrun
    );

    modport slave (
        input  frame_start, active, coll_wall, report_ready,
        output coll, coll_idx, onehot_err, report_valid, report_mask,
               report_first, report_any, overrun
    );
endinterface

// File: rtl/collision_debounce.sv
// -----------------------------------------------------------------------------
// collision_debounce
// Counts consecutive hit cycles on the same wall. confirm pulses in the cycle
// the count reaches DEBOUNCE.
//   clk, reset : clock and synchronous active-high reset
//   restart    : frame boundary. The current hit counts as cycle 1.
//   hit        : qualified hit in this cycle
//   idx        : wall index of the hit
//   confirm    : the hit in this cycle completes the debounce
// -----------------------------------------------------------------------------
module collision_debounce #(
    parameter int DEBOUNCE = 2,
    parameter int IDXW     = 4
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic            hit,
    input  logic [IDXW-1:0] idx,
    output logic            confirm
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic [3:0]      cnt_p1;
    logic [3:0]      cnt_next;
    logic [IDXW-1:0] prev_idx_p1;
    logic            inc;

    always_comb begin
        // A nonzero count means the previous cycle was a hit, so prev_idx_p1 is valid.
        inc      = hit && !restart && (cnt_p1 != 4'd0) && (idx == prev_idx_p1);
        cnt_next = 4'd0;
        if (hit) begin
            if (inc) cnt_next = (cnt_p1 == DB) ? cnt_p1 : cnt_p1 + 4'd1;
            else     cnt_next = 4'd1;
        end
        // Fire only on the transition into DB. A saturated count does not re-fire.
        confirm = hit && (cnt_next == DB) && !(inc && (cnt_p1 == DB));
    end

    // ---- stage p1: count register ----
    always_ff @(posedge clk) begin
        if (reset) cnt_p1 <= 4'd0;
        else       cnt_p1 <= cnt_next;
    end

    always_ff @(posedge clk) begin
        if (hit) prev_idx_p1 <= idx;
    end
endmodule

// File: rtl/collision_tracker.sv
// -----------------------------------------------------------------------------
// collision_tracker
// Per-frame collision tracker for the hero playfield.
//   clk, reset : clock and synchronous active-high reset
//   bus.slave  : inputs frame_start, active, coll_wall and report_ready.
//                Outputs coll and coll_idx (instantaneous hit, latency 1),
//                onehot_err, the frame report (report_valid, report_mask,
//                report_first, report_any) and the sticky overrun flag.
// -----------------------------------------------------------------------------
module collision_tracker
    import hero_pkg::*;
#(
    parameter int                   NUM_WALLS  = DEF_NUM_WALLS,
    parameter logic [NUM_WALLS-1:0] VALID_MASK = NUM_WALLS'(DEF_VALID_MASK),
    parameter int                   DEBOUNCE   = 2,
    parameter int                   IDXW       = $clog2(NUM_WALLS)
)(
    input  logic                clk,
    input  logic                reset,
    collision_tracker_if.slave  bus
);
    localparam int PADW = MAX_WALLS - NUM_WALLS;

    logic [MAX_WALLS-1:0] active_w;
    logic                 sel_onehot;
    logic [IDXW-1:0]      sel_idx;
    logic                 hit;
    logic                 confirm;
    logic                 accum_en;

    state_t               state_p1;
    logic [NUM_WALLS-1:0] acc_mask_p1, acc_next;
    logic                 first_valid_p1, fv_next;
    logic [IDXW-1:0]      first_idx_p1, fidx_next;

    logic                 coll_p1;
    logic [IDXW-1:0]      coll_idx_p1;
    logic                 onehot_err_p1;
    logic                 report_valid_p1;
    logic [NUM_WALLS-1:0] report_mask_p1;
    logic [IDXW-1:0]      report_first_p1;
    logic                 overrun_p1;

    assign active_w   = {{PADW{1'b0}}, bus.active};
    assign sel_onehot = is_onehot(active_w);
    assign sel_idx    = IDXW'(onehot_to_idx(active_w));
    assign hit        = sel_onehot && |(bus.active & bus.coll_wall & VALID_MASK);

    collision_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .IDXW     (IDXW)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .restart (bus.frame_start),
        .hit     (hit),
        .idx     (sel_idx),
        .confirm (confirm)
    );

    // frame_start clears the accumulators first. A confirm in the same cycle
    // then lands in the new frame.
    always_comb begin
        accum_en  = (state_p1 != IDLE) || bus.frame_start;
        acc_next  = acc_mask_p1;
        fv_next   = first_valid_p1;
        fidx_next = first_idx_p1;
        if (bus.frame_start) begin
            acc_next = '0;
            fv_next  = 1'b0;
        end
        if (accum_en && confirm) begin
            acc_next[sel_idx] = 1'b1;
            if (!fv_next) begin
                fv_next   = 1'b1;
                fidx_next = sel_idx;
            end
        end
    end

    // ---- stage p1: FSM, accumulators and registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1        <= IDLE;
            acc_mask_p1     <= '0;
            first_valid_p1  <= 1'b0;
            coll_p1         <= 1'b0;
            coll_idx_p1     <= '0;
            onehot_err_p1   <= 1'b0;
            report_valid_p1 <= 1'b0;
            report_mask_p1  <= '0;
            report_first_p1 <= '0;
            overrun_p1      <= 1'b0;
        end else begin
            coll_p1        <= hit;
            if (sel_onehot) coll_idx_p1 <= sel_idx;
            onehot_err_p1  <= (bus.active != '0) && !sel_onehot;
            acc_mask_p1    <= acc_next;
            first_valid_p1 <= fv_next;
            case (state_p1)
                IDLE: begin
                    if (bus.frame_start) state_p1 <= SCAN;
                end
                SCAN: begin
                    if (bus.frame_start) begin
                        report_mask_p1  <= acc_mask_p1;
                        report_first_p1 <= first_valid_p1 ? first_idx_p1 : '0;
                        report_valid_p1 <= 1'b1;
                        state_p1        <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.frame_start) begin
                        // Replace the pending report. An unaccepted report is lost.
                        report_mask_p1  <= acc_mask_p1;
                        report_first_p1 <= first_valid_p1 ? first_idx_p1 : '0;
                        if (!bus.report_ready) overrun_p1 <= 1'b1;
                    end else if (bus.report_ready) begin
                        report_valid_p1 <= 1'b0;
                        state_p1        <= SCAN;
                    end
                end
                default: state_p1 <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        first_idx_p1 <= fidx_next;
    end

    assign bus.coll         = coll_p1;
    assign bus.coll_idx     = coll_idx_p1;
    assign bus.onehot_err   = onehot_err_p1;
    assign bus.report_valid = report_valid_p1;
    assign bus.report_mask  = report_mask_p1;
    assign bus.report_first = report_first_p1;
    assign bus.report_any   = |report_mask_p1;
    assign bus.overrun      = overrun_p1;
endmodule
